// File: rtl/sprite_motion_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion_unit
//  Purpose  : One maze sprite: run/stop FSM, move-tick divider, buffered turn
//             request with time-to-live, edge clamp / horizontal tunnel wrap,
//             and a registered pixel-hit flag for the colour mux.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_motion_unit #(
    parameter int WIDTH    = 96,
    parameter int HEIGHT   = 72,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int X_START  = 272,
    parameter int Y_START  = 204,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1000000,
    parameter int TURN_TTL = 8,
    parameter int WRAP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       win,
    input  logic       loose,
    input  logic       uE,
    input  logic       dE,
    input  logic       lE,
    input  logic       rE,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [9:0] xLoc,
    output logic [8:0] yLoc,
    output logic [1:0] dir,
    output logic       moving,
    output logic [1:0] state,
    output logic       won,
    output logic       hit
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TTL_W = $clog2(TURN_TTL + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);
    localparam logic [TTL_W-1:0] c_ttl_init = TTL_W'(TURN_TTL);
    localparam logic [10:0]      c_x_max    = 11'(SCREEN_W - WIDTH);
    localparam logic [10:0]      c_y_max    = 11'(SCREEN_H - HEIGHT);
    localparam logic [10:0]      c_step     = 11'(STEP);
    localparam logic [10:0]      c_width    = 11'(WIDTH);
    localparam logic [10:0]      c_height   = 11'(HEIGHT);
    localparam logic [9:0]       c_x_start  = 10'(X_START);
    localparam logic [8:0]       c_y_start  = 9'(Y_START);

    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       xloc_q, xloc_d;
    logic [8:0]       yloc_q, yloc_d;
    logic [1:0]       dir_q, dir_d;
    logic             moving_q, moving_d;
    logic             won_q, won_d;
    logic             hit_q, hit_d;
    logic             pend_v_q, pend_v_d;
    logic [1:0]       pend_dir_q, pend_dir_d;
    logic [TTL_W-1:0] pend_ttl_q, pend_ttl_d;

    logic [10:0] x_ext, y_ext, x_right, x_left, y_up, y_down;
    logic [3:0]  en_vec;
    logic        tick;
    logic        req_any;
    logic [1:0]  req_dir;
    logic        pv;
    logic [1:0]  pd;
    logic [TTL_W-1:0] pt;
    logic        do_move;
    logic [1:0]  move_dir;

    // Candidate positions one step away in each direction, with clamp / wrap.
    always_comb begin
        x_ext   = {1'b0, xloc_q};
        y_ext   = {2'b00, yloc_q};
        x_right = x_ext + c_step;
        if (x_right > c_x_max) begin
            x_right = (WRAP != 0) ? 11'd0 : c_x_max;
        end
        x_left = x_ext - c_step;
        if (x_ext < c_step) begin
            x_left = (WRAP != 0) ? c_x_max : 11'd0;
        end
        y_up = y_ext - c_step;
        if (y_ext < c_step) begin
            y_up = 11'd0;
        end
        y_down = y_ext + c_step;
        if (y_down > c_y_max) begin
            y_down = c_y_max;
        end
    end

    // Request decode, tick detection and all next-state logic.
    always_comb begin
        en_vec   = {rE, lE, dE, uE};
        tick     = (state_q == ST_RUN) && (cnt_q == c_cnt_last);
        req_any  = up | down | left | right;
        req_dir  = up ? c_dir_up : (down ? c_dir_down : (left ? c_dir_left : c_dir_right));

        state_d    = state_q;
        cnt_d      = cnt_q;
        xloc_d     = xloc_q;
        yloc_d     = yloc_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        won_d      = won_q;
        pend_v_d   = pend_v_q;
        pend_dir_d = pend_dir_q;
        pend_ttl_d = pend_ttl_q;
        pv         = pend_v_q;
        pd         = pend_dir_q;
        pt         = pend_ttl_q;
        do_move    = 1'b0;
        move_dir   = dir_q;

        hit_d = ({1'b0, x} >= x_ext) && ({1'b0, x} < x_ext + c_width) &&
                ({2'b00, y} >= y_ext) && ({2'b00, y} < y_ext + c_height);

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                pend_v_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                cnt_d    = '0;
                pend_v_d = 1'b0;
                if (start) begin
                    state_d  = ST_IDLE;
                    xloc_d   = c_x_start;
                    yloc_d   = c_y_start;
                    dir_d    = c_dir_left;
                    moving_d = 1'b0;
                end
            end
            ST_RUN: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                // A fresh request replaces pending before the tick looks at it.
                if (req_any) begin
                    pv = 1'b1;
                    pd = req_dir;
                    pt = c_ttl_init;
                end
                if (tick) begin
                    if (pv && en_vec[pd]) begin
                        dir_d    = pd;
                        move_dir = pd;
                        do_move  = 1'b1;
                        pv       = 1'b0;
                    end else begin
                        do_move = en_vec[dir_q];
                        if (pv) begin
                            pt = pt - TTL_W'(1);
                            if (pt == '0) begin
                                pv = 1'b0;
                            end
                        end
                    end
                    moving_d = do_move;
                end
                pend_v_d   = pv;
                pend_dir_d = pd;
                pend_ttl_d = pt;
                if (win | loose) begin
                    state_d = ST_DONE;
                    won_d   = win;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_move) begin
            case (move_dir)
                c_dir_up:    yloc_d = y_up[8:0];
                c_dir_down:  yloc_d = y_down[8:0];
                c_dir_left:  xloc_d = x_left[9:0];
                default:     xloc_d = x_right[9:0];
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            xloc_q     <= c_x_start;
            yloc_q     <= c_y_start;
            dir_q      <= c_dir_left;
            moving_q   <= 1'b0;
            won_q      <= 1'b0;
            hit_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_dir_q <= 2'd0;
            pend_ttl_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xloc_q     <= xloc_d;
            yloc_q     <= yloc_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            won_q      <= won_d;
            hit_q      <= hit_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            pend_ttl_q <= pend_ttl_d;
        end
    end

    assign xLoc   = xloc_q;
    assign yLoc   = yloc_q;
    assign dir    = dir_q;
    assign moving = moving_q;
    assign state  = state_q;
    assign won    = won_q;
    assign hit    = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion_unit
//  Purpose  : Self-checking bench for sprite_motion_unit. Four instances share
//             stimulus: A (272, wrap), B (541, clamp), C (541, wrap), D (3, wrap),
//             all with STEP=2, TICK_DIV=4, TURN_TTL=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_motion_unit;

    localparam int NI   = 4;
    localparam int TDIV = 4;
    localparam int STP  = 2;
    localparam int TTL  = 8;
    localparam int XMAX = 640 - 96;
    localparam int YMAX = 480 - 72;

    logic       clk = 1'b0;
    logic       reset, start, win, loose, uE, dE, lE, rE, up, down, left, right;
    logic [9:0] x;
    logic [8:0] y;

    logic [9:0] xl [NI];
    logic [8:0] yl [NI];
    logic [1:0] dr [NI];
    logic [1:0] st [NI];
    logic       mv [NI];
    logic       wn [NI];
    logic       ht [NI];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one entry per instance.
    int mx[NI], my[NI], mdir[NI], mmov[NI], mst[NI], mwon[NI], mhit[NI];
    int pv[NI], pd[NI], pt[NI], mcnt[NI];
    int mticks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int XS = (g == 0) ? 272 : ((g == 3) ? 3 : 541);
        localparam int WR = (g == 1) ? 0 : 1;
        sprite_motion_unit #(
            .WIDTH(96), .HEIGHT(72), .SCREEN_W(640), .SCREEN_H(480),
            .X_START(XS), .Y_START(204), .STEP(STP), .TICK_DIV(TDIV),
            .TURN_TTL(TTL), .WRAP(WR)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start), .win(win), .loose(loose),
            .uE(uE), .dE(dE), .lE(lE), .rE(rE),
            .up(up), .down(down), .left(left), .right(right),
            .x(x), .y(y),
            .xLoc(xl[g]), .yLoc(yl[g]), .dir(dr[g]), .moving(mv[g]),
            .state(st[g]), .won(wn[g]), .hit(ht[g])
        );
    end

    function automatic int xs_of(int i);
        return (i == 0) ? 272 : ((i == 3) ? 3 : 541);
    endfunction

    function automatic int wr_of(int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int en_of(int d);
        case (d)
            0:       return int'(uE);
            1:       return int'(dE);
            2:       return int'(lE);
            default: return int'(rE);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mx[i] = xs_of(i); my[i] = 204; mdir[i] = 2; mmov[i] = 0;
            mst[i] = 0; mwon[i] = 0; mhit[i] = 0;
            pv[i] = 0; pd[i] = 0; pt[i] = 0; mcnt[i] = 0;
        end
    endtask

    task automatic model_move(int i, int d);
        if (d == 3) begin
            mx[i] = (mx[i] + STP > XMAX) ? (wr_of(i) != 0 ? 0 : XMAX) : mx[i] + STP;
        end else if (d == 2) begin
            mx[i] = (mx[i] < STP) ? (wr_of(i) != 0 ? XMAX : 0) : mx[i] - STP;
        end else if (d == 0) begin
            my[i] = (my[i] < STP) ? 0 : my[i] - STP;
        end else begin
            my[i] = (my[i] + STP > YMAX) ? YMAX : my[i] + STP;
        end
    endtask

    // One clock edge of the game rules, using the inputs held across the edge.
    task automatic model_edge();
        int  xi, yi, rq;
        bit  req, tk;
        xi  = int'(x);
        yi  = int'(y);
        req = up | down | left | right;
        rq  = up ? 0 : (down ? 1 : (left ? 2 : 3));
        if (mst[0] == 1 && mcnt[0] == TDIV - 1) mticks++;
        for (int i = 0; i < NI; i++) begin
            mhit[i] = (xi >= mx[i] && xi < mx[i] + 96 && yi >= my[i] && yi < my[i] + 72) ? 1 : 0;
            if (mst[i] == 1) begin
                tk = (mcnt[i] == TDIV - 1);
                if (req) begin pv[i] = 1; pd[i] = rq; pt[i] = TTL; end
                if (tk) begin
                    if (pv[i] != 0 && en_of(pd[i]) != 0) begin
                        mdir[i] = pd[i]; model_move(i, pd[i]); mmov[i] = 1; pv[i] = 0;
                    end else begin
                        if (en_of(mdir[i]) != 0) begin model_move(i, mdir[i]); mmov[i] = 1; end
                        else mmov[i] = 0;
                        if (pv[i] != 0) begin
                            pt[i]--;
                            if (pt[i] == 0) pv[i] = 0;
                        end
                    end
                end
                mcnt[i] = tk ? 0 : mcnt[i] + 1;
                if (win | loose) begin mst[i] = 2; mwon[i] = win ? 1 : 0; end
            end else begin
                pv[i] = 0; mcnt[i] = 0;
                if (start) begin
                    if (mst[i] == 0) mst[i] = 1;
                    else begin
                        mst[i] = 0; mx[i] = xs_of(i); my[i] = 204; mdir[i] = 2; mmov[i] = 0;
                    end
                end
            end
        end
    endtask

    // Advance one clock: model follows the edge, return at the next falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic wait_ticks(int n);
        int tgt, k;
        tgt = mticks + n;
        k   = 0;
        while (mticks < tgt && k < n * TDIV + 8) begin
            step();
            k++;
        end
        n_cmp++;
        if (mticks < tgt) begin
            n_bad++;
            $display("FAIL tick_wait: reached %0d ticks, required %0d", mticks, tgt);
        end
    endtask

    task automatic clear_inputs();
        start = 0; win = 0; loose = 0;
        uE = 0; dE = 0; lE = 0; rE = 0;
        up = 0; down = 0; left = 0; right = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        x = '0; y = '0;
        model_reset();
        step(); step();
        n_cmp++; if (xl[0] !== 10'd272) begin n_bad++; $display("FAIL reset_xLoc: got %0d want 272", xl[0]); end
        n_cmp++; if (yl[0] !== 9'd204)  begin n_bad++; $display("FAIL reset_yLoc: got %0d want 204", yl[0]); end
        n_cmp++; if (dr[0] !== 2'd2)    begin n_bad++; $display("FAIL reset_dir: got %0d want 2", dr[0]); end
        n_cmp++; if (mv[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_moving: got %0d want 0", mv[0]); end
        n_cmp++; if (st[0] !== 2'd0)    begin n_bad++; $display("FAIL reset_state: got %0d want 0", st[0]); end
        n_cmp++; if (wn[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_won: got %0d want 0", wn[0]); end
        n_cmp++; if (ht[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_hit: got %0d want 0", ht[0]); end
        n_cmp++; if (xl[3] !== 10'd3)   begin n_bad++; $display("FAIL reset_xLoc_D: got %0d want 3", xl[3]); end
        reset = 1'b0;
    endtask

    task automatic test_hit();
        x = 10'd300; y = 9'd210; step();
        n_cmp++; if (ht[0] !== 1'b1) begin n_bad++; $display("FAIL hit_inside: got %0d want 1", ht[0]); end
        n_cmp++; if (ht[3] !== 1'b0) begin n_bad++; $display("FAIL hit_other: got %0d want 0", ht[3]); end
        x = 10'd271; step();
        n_cmp++; if (ht[0] !== 1'b0) begin n_bad++; $display("FAIL hit_left_edge: got %0d want 0", ht[0]); end
        x = 10'd367; y = 9'd275; step();
        n_cmp++; if (ht[0] !== 1'b1) begin n_bad++; $display("FAIL hit_corner: got %0d want 1", ht[0]); end
        x = 10'd368; step();
        n_cmp++; if (ht[0] !== 1'b0) begin n_bad++; $display("FAIL hit_right_edge: got %0d want 0", ht[0]); end
        y = 9'd276; x = 10'd300; step();
        n_cmp++; if (ht[0] !== 1'b0) begin n_bad++; $display("FAIL hit_bottom_edge: got %0d want 0", ht[0]); end
        x = '0; y = '0;
    endtask

    task automatic test_first_move();
        rE = 1; right = 1; start = 1;
        step();
        start = 0;
        n_cmp++; if (st[0] !== 2'd1) begin n_bad++; $display("FAIL start_run: got %0d want 1", st[0]); end
        step(); step(); step();
        n_cmp++; if (xl[0] !== 10'd272) begin n_bad++; $display("FAIL pre_tick_x: got %0d want 272", xl[0]); end
        step();
        n_cmp++; if (xl[0] !== 10'd274) begin n_bad++; $display("FAIL first_tick_x: got %0d want 274", xl[0]); end
        n_cmp++; if (dr[0] !== 2'd3)    begin n_bad++; $display("FAIL first_tick_dir: got %0d want 3", dr[0]); end
        n_cmp++; if (mv[0] !== 1'b1)    begin n_bad++; $display("FAIL first_tick_moving: got %0d want 1", mv[0]); end
        n_cmp++; if (xl[1] !== 10'd543) begin n_bad++; $display("FAIL clamp_step1: got %0d want 543", xl[1]); end
        n_cmp++; if (xl[3] !== 10'd5)   begin n_bad++; $display("FAIL d_step1: got %0d want 5", xl[3]); end
        wait_ticks(1);
        n_cmp++; if (xl[0] !== 10'd276) begin n_bad++; $display("FAIL second_tick_x: got %0d want 276", xl[0]); end
        n_cmp++; if (xl[1] !== 10'd544) begin n_bad++; $display("FAIL right_clamp: got %0d want 544", xl[1]); end
        n_cmp++; if (xl[2] !== 10'd0)   begin n_bad++; $display("FAIL right_wrap: got %0d want 0", xl[2]); end
        right = 0;
    endtask

    task automatic test_turn_buffer();
        uE = 0; rE = 1;
        up = 1; step(); up = 0;
        wait_ticks(3);
        uE = 1;
        wait_ticks(1);
        n_cmp++; if (dr[0] !== 2'd0)   begin n_bad++; $display("FAIL turn_dir: got %0d want 0", dr[0]); end
        n_cmp++; if (yl[0] !== 9'd202) begin n_bad++; $display("FAIL turn_y: got %0d want 202", yl[0]); end
        n_cmp++; if (yl[3] !== 9'd202) begin n_bad++; $display("FAIL turn_y_D: got %0d want 202", yl[3]); end
        uE = 0;
        right = 1; step(); right = 0;
        wait_ticks(1);
        n_cmp++; if (dr[0] !== 2'd3) begin n_bad++; $display("FAIL back_right_dir: got %0d want 3", dr[0]); end
        up = 1; step(); up = 0;
        wait_ticks(9);
        uE = 1;
        wait_ticks(1);
        n_cmp++; if (dr[0] !== 2'd3)   begin n_bad++; $display("FAIL expired_dir: got %0d want 3", dr[0]); end
        n_cmp++; if (yl[0] !== 9'd202) begin n_bad++; $display("FAIL expired_y: got %0d want 202", yl[0]); end
        uE = 0;
    endtask

    task automatic test_all_disabled();
        int sx0, sy0, sx2;
        uE = 0; dE = 0; lE = 0; rE = 0;
        sx0 = mx[0]; sy0 = my[0]; sx2 = mx[2];
        for (int k = 0; k < 5; k++) begin
            up = 1'($urandom_range(1)); down = 1'($urandom_range(1));
            left = 1'($urandom_range(1)); right = 1'($urandom_range(1));
            wait_ticks(1);
            n_cmp++; if (mv[0] !== 1'b0) begin n_bad++; $display("FAIL blocked_moving: got %0d want 0", mv[0]); end
            n_cmp++; if (xl[0] !== 10'(sx0) || yl[0] !== 9'(sy0)) begin
                n_bad++; $display("FAIL blocked_pos: got (%0d,%0d) want (%0d,%0d)", xl[0], yl[0], sx0, sy0);
            end
            n_cmp++; if (xl[2] !== 10'(sx2)) begin n_bad++; $display("FAIL blocked_pos_C: got %0d want %0d", xl[2], sx2); end
        end
        up = 0; down = 0; left = 0; right = 0;
    endtask

    task automatic test_win_loose();
        win = 1; loose = 1; step(); win = 0; loose = 0;
        n_cmp++; if (st[0] !== 2'd2) begin n_bad++; $display("FAIL done_state: got %0d want 2", st[0]); end
        n_cmp++; if (wn[0] !== 1'b1) begin n_bad++; $display("FAIL won_priority: got %0d want 1", wn[0]); end
        loose = 1; step(); loose = 0;
        n_cmp++; if (st[0] !== 2'd2 || wn[0] !== 1'b1) begin
            n_bad++; $display("FAIL done_ignores_loose: got state %0d won %0d want 2/1", st[0], wn[0]);
        end
        start = 1; step(); start = 0;
        n_cmp++; if (st[0] !== 2'd0) begin n_bad++; $display("FAIL restart_idle: got %0d want 0", st[0]); end
        n_cmp++; if (xl[0] !== 10'd272 || yl[0] !== 9'd204) begin
            n_bad++; $display("FAIL reload_pos: got (%0d,%0d) want (272,204)", xl[0], yl[0]);
        end
        n_cmp++; if (dr[0] !== 2'd2 || mv[0] !== 1'b0) begin
            n_bad++; $display("FAIL reload_dir_moving: got %0d/%0d want 2/0", dr[0], mv[0]);
        end
        loose = 1; step(); loose = 0;
        n_cmp++; if (st[0] !== 2'd0) begin n_bad++; $display("FAIL idle_ignores_loose: got %0d want 0", st[0]); end
        start = 1; step(); start = 0;
        n_cmp++; if (st[0] !== 2'd1) begin n_bad++; $display("FAIL restart_run: got %0d want 1", st[0]); end
    endtask

    task automatic test_left_wrap();
        lE = 1; left = 1;
        step(); step(); step(); step();
        n_cmp++; if (xl[3] !== 10'd1)   begin n_bad++; $display("FAIL left_to_1: got %0d want 1", xl[3]); end
        n_cmp++; if (xl[0] !== 10'd270) begin n_bad++; $display("FAIL left_A: got %0d want 270", xl[0]); end
        wait_ticks(1);
        n_cmp++; if (xl[3] !== 10'd544) begin n_bad++; $display("FAIL left_wrap: got %0d want 544", xl[3]); end
        n_cmp++; if (xl[0] !== 10'd268) begin n_bad++; $display("FAIL left_A2: got %0d want 268", xl[0]); end
        left = 0;
    endtask

    task automatic test_reset_mid();
        lE = 0; uE = 0;
        up = 1; step(); up = 0;
        #2 reset = 1;
        model_reset();
        #1;
        n_cmp++; if (xl[0] !== 10'd272 || yl[0] !== 9'd204) begin
            n_bad++; $display("FAIL async_reset_pos: got (%0d,%0d) want (272,204)", xl[0], yl[0]);
        end
        n_cmp++; if (st[0] !== 2'd0 || dr[0] !== 2'd2 || mv[0] !== 1'b0 || wn[0] !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_ctrl: got st %0d dir %0d mv %0d won %0d want 0/2/0/0",
                              st[0], dr[0], mv[0], wn[0]);
        end
        step();
        reset = 0;
        start = 1; lE = 1; uE = 1; step(); start = 0;
        step(); step(); step();
        n_cmp++; if (xl[0] !== 10'd272) begin n_bad++; $display("FAIL post_reset_pre_tick: got %0d want 272", xl[0]); end
        step();
        n_cmp++; if (xl[0] !== 10'd270) begin n_bad++; $display("FAIL post_reset_left: got %0d want 270", xl[0]); end
        n_cmp++; if (dr[0] !== 2'd2 || yl[0] !== 9'd204) begin
            n_bad++; $display("FAIL stale_pending: got dir %0d y %0d want 2/204", dr[0], yl[0]);
        end
    endtask

    task automatic test_random();
        int tx, r;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NI; i++) begin
                n_cmp++; if (xl[i] !== 10'(mx[i])) begin n_bad++; $display("FAIL rnd_xLoc[%0d] cyc %0d: got %0d want %0d", i, k, xl[i], mx[i]); end
                n_cmp++; if (yl[i] !== 9'(my[i]))  begin n_bad++; $display("FAIL rnd_yLoc[%0d] cyc %0d: got %0d want %0d", i, k, yl[i], my[i]); end
                n_cmp++; if (dr[i] !== 2'(mdir[i])) begin n_bad++; $display("FAIL rnd_dir[%0d] cyc %0d: got %0d want %0d", i, k, dr[i], mdir[i]); end
                n_cmp++; if (mv[i] !== 1'(mmov[i])) begin n_bad++; $display("FAIL rnd_moving[%0d] cyc %0d: got %0d want %0d", i, k, mv[i], mmov[i]); end
                n_cmp++; if (st[i] !== 2'(mst[i])) begin n_bad++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d want %0d", i, k, st[i], mst[i]); end
                n_cmp++; if (wn[i] !== 1'(mwon[i])) begin n_bad++; $display("FAIL rnd_won[%0d] cyc %0d: got %0d want %0d", i, k, wn[i], mwon[i]); end
                n_cmp++; if (ht[i] !== 1'(mhit[i])) begin n_bad++; $display("FAIL rnd_hit[%0d] cyc %0d: got %0d want %0d", i, k, ht[i], mhit[i]); end
            end
            uE = 1'($urandom_range(1)); dE = 1'($urandom_range(1));
            lE = 1'($urandom_range(1)); rE = 1'($urandom_range(1));
            up    = ($urandom_range(99) < 6);
            down  = ($urandom_range(99) < 6);
            left  = ($urandom_range(99) < 6);
            right = ($urandom_range(99) < 6);
            start = ($urandom_range(99) < 3);
            win   = ($urandom_range(99) < 1);
            loose = ($urandom_range(99) < 1);
            r  = int'($urandom_range(NI - 1));
            tx = mx[r] - 10 + int'($urandom_range(115));
            if (tx < 0) tx = 0;
            x = 10'(tx);
            tx = my[r] - 8 + int'($urandom_range(90));
            if (tx < 0) tx = 0;
            if (tx > 511) tx = 511;
            y = 9'(tx);
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_first_move();
        test_turn_buffer();
        test_all_disabled();
        test_win_loose();
        test_left_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sprite_motion_unit.md
# sprite_motion_unit

Parametrised successor to the single-sprite player block. It owns one maze sprite's run/stop state, a move-tick divider, a buffered turn request with time-to-live, and screen-edge clamping or horizontal tunnel wrap, and produces the sprite's position plus a registered pixel-hit flag for the colour mux. One instance drives the player; further instances with different start positions drive ghosts. It sits between the controller/maze-enable logic and the display driver.

## Interface
- WIDTH, 96, sprite width in pixels
- HEIGHT, 72, sprite height in pixels
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- X_START, 272, reset/reload x (top-left)
- Y_START, 204, reset/reload y
- STEP, 1, pixels moved per move tick (1..WIDTH)
- TICK_DIV, 1000000, clock cycles per move tick (>=1)
- TURN_TTL, 8, move ticks a buffered turn survives (>=1)
- WRAP, 1, 1 = horizontal tunnel wrap, 0 = clamp

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  start/restart pulse
- win, loose  in  1  game-over events
- uE, dE, lE, rE  in  1  maze permits a move in that direction this tick
- up, down, left, right  in  1  level direction requests
- x  in  10  display pixel column
- y  in  9  display pixel row
- xLoc  out  10  sprite left edge
- yLoc  out  9  sprite top edge
- dir  out  2  current heading: 0 up, 1 down, 2 left, 3 right
- moving  out  1  sprite moved on the last tick
- state  out  2  0 IDLE, 1 RUN, 2 DONE
- won  out  1  last DONE was entered by win
- hit  out  1  (x,y) is inside the sprite box, registered

## Operation
- Reset values: xLoc=X_START, yLoc=Y_START, dir=2, moving=0, state=IDLE, won=0, hit=0, pending invalid, tick counter 0.
- FSM:
  - IDLE→RUN on start.
  - RUN→DONE on win|loose; won<=win, so win has priority if both are asserted.
  - DONE→IDLE on start: reload X_START/Y_START, dir=2, moving=0.
  - start in RUN is ignored. win/loose outside RUN are ignored.
- Tick counter: runs only in RUN, counting 0..TICK_DIV-1. tick = (cnt==TICK_DIV-1). The counter is held at 0 in IDLE/DONE.
- Request capture (RUN only, any cycle): if any request is high, priority up>down>left>right selects one direction. It is written to pending with ttl=TURN_TTL, overwriting any older pending. In IDLE/DONE requests are ignored and pending is cleared.
- On tick (same clock edge), in this order:
  1. If pending is valid and its enable is high: dir<=pending, move that way, clear pending.
  2. Else if the enable for dir is high: move in dir.
  3. Else hold: moving<=0, no position change.
  - moving<=1 in cases 1 and 2.
  - If pending survives the tick, ttl decrements; pending is cleared when ttl reaches 0.
  - A request captured in the same cycle as the tick replaces pending before evaluation.
  - Reversals are not special-cased.
- Arithmetic uses 11-bit intermediates; no overflow is possible.
  - Right: if xLoc+STEP > SCREEN_W-WIDTH, then WRAP ? 0 : SCREEN_W-WIDTH; else xLoc+STEP.
  - Left: if xLoc < STEP, then WRAP ? SCREEN_W-WIDTH : 0; else xLoc-STEP.
  - Up/down always clamp to 0..SCREEN_H-HEIGHT.
  - A clamped move that leaves the position unchanged still reports moving=1.
- hit <= (x>=xLoc)&&(x<xLoc+WIDTH)&&(y>=yLoc)&&(y<yLoc+HEIGHT). It updates every cycle in every state.

## Timing
- The state change occurs on the edge where start/win/loose is sampled high.
- The first move tick is the TICK_DIV-th cycle after entering RUN.
- Position, dir, and moving update on the tick edge and are visible the next cycle.
- Position latency from an enable change is at most one tick.
- hit lags (x,y) by 1 cycle.
- Reset mid-operation returns every output to its reset value immediately (asynchronously), including pending and the counter.

## Test plan
- Reset, start, rE=1, right held, TICK_DIV=4, STEP=2 → xLoc 272→274 on cycle 4 after RUN, moving=1, dir=3.
- Heading right with uE=0; pulse up for 1 cycle; raise uE 3 ticks later with TURN_TTL=8 → turn taken on that tick, dir=0, yLoc-=STEP. Repeat with uE raised after 9 ticks → no turn, pending expired.
- WRAP=1, xLoc=543 (SCREEN_W-WIDTH-1), right, STEP=2 → xLoc=0. WRAP=0 → xLoc=544. Left from xLoc=1, WRAP=1 → 544.
- All enables 0 while RUN → moving=0 on every tick, position constant.
- win and loose in the same cycle in RUN → state=DONE, won=1. Then start → IDLE, xLoc=272, yLoc=204. Another start → RUN.
- Assert reset mid-RUN with pending valid → all outputs at reset values. After release, a tick with lE=1 moves left; the stale pending has no effect.
